// File: rtl/full_axi_arb_pkg.sv
// Shared types and constants for the full_axi AXI4-Lite arbiter.
package full_axi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [1:0] RESP_SLVERR      = 2'b10;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/full_axi_lite_arbiter_rr.sv
// Two-way round-robin grant: ptr_i holds the last granted requester.
module full_axi_rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       en_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  always_comb begin
    gnt_o = 2'b00;
    ptr_o = ptr_i;
    if (en_i) begin
      if (valid0_i && valid1_i) begin
        if (ptr_i) begin
          gnt_o = 2'b01;
          ptr_o = 1'b0;
        end else begin
          gnt_o = 2'b10;
          ptr_o = 1'b1;
        end
      end else if (valid0_i) begin
        gnt_o = 2'b01;
        ptr_o = 1'b0;
      end else if (valid1_i) begin
        gnt_o = 2'b10;
        ptr_o = 1'b1;
      end else begin
        gnt_o = 2'b00;
        ptr_o = ptr_i;
      end
    end else begin
      gnt_o = 2'b00;
      ptr_o = ptr_i;
    end
  end

endmodule

// File: rtl/full_axi_lite_arbiter.sv
// Round-robin sharing of the full_axi AXI4-Lite register slave between two requesters.
// Build macro FULL_AXI_ARB_ALIGN_CHECK_EN: misaligned addresses complete with SLVERR, no AXI traffic.
module full_axi_lite_arbiter
  import full_axi_arb_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            req0_valid,
  input  logic                            req0_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_wdata,
  output logic                            req0_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   req0_rdata,
  output logic [1:0]                      req0_resp,
  input  logic                            req1_valid,
  input  logic                            req1_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_wdata,
  output logic                            req1_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   req1_rdata,
  output logic [1:0]                      req1_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

`ifdef FULL_AXI_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK_EN = 1'b1;
`else
  localparam bit ALIGN_CHECK_EN = 1'b0;
`endif

  arb_state_e state_q, state_d;
  logic ptr_q, ptr_d, gnt1_q, gnt1_d, wr_q, wr_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d, sel_addr_s;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, sel_wdata_s, fin_rdata_s;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic done0_q, done0_d, done1_q, done1_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0] resp0_q, resp0_d, resp1_q, resp1_d, fin_resp_s, gnt_s;
  logic sel_write_s, fin_s, ptr_nxt_s, arb_en_s;

  assign arb_en_s = (state_q == ST_IDLE);

  full_axi_rr_arb2 u_rr (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .en_i     (arb_en_s),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt_s),
    .ptr_o    (ptr_nxt_s)
  );

  always_comb begin
    if (gnt_s[1]) begin
      sel_write_s = req1_write;
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
    end else begin
      sel_write_s = req0_write;
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
    end
  end

  always_comb begin
    state_d = state_q;   ptr_d = ptr_q;     gnt1_d = gnt1_q;
    wr_d = wr_q;         addr_d = addr_q;   wdata_d = wdata_q;
    awvalid_d = awvalid_q; wvalid_d = wvalid_q; bready_d = bready_q;
    arvalid_d = arvalid_q; rready_d = rready_q;
    fin_s = 1'b0; fin_rdata_s = '0; fin_resp_s = RESP_OKAY;
    case (state_q)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          ptr_d = ptr_nxt_s; gnt1_d = gnt_s[1];
          wr_d = sel_write_s; addr_d = sel_addr_s; wdata_d = sel_wdata_s;
          if (ALIGN_CHECK_EN && addr_misaligned(sel_addr_s[1:0])) begin
            state_d = ST_DONE; fin_s = 1'b1; fin_resp_s = RESP_SLVERR;
          end else if (sel_write_s) begin
            state_d = ST_WR; awvalid_d = 1'b1; wvalid_d = 1'b1;
          end else begin
            state_d = ST_RD_ADDR; arvalid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      // AW and W retire independently; the response phase waits for both.
      ST_WR: begin
        awvalid_d = awvalid_q && !M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d = ST_WR_RESP; bready_d = 1'b1;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_d = ST_DONE; bready_d = 1'b0; fin_s = 1'b1; fin_resp_s = M_AXI_BRESP;
        end else begin
          state_d = ST_WR_RESP;
        end
      end
      ST_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = ST_RD_DATA; arvalid_d = 1'b0; rready_d = 1'b1;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          state_d = ST_DONE; rready_d = 1'b0; fin_s = 1'b1;
          fin_rdata_s = M_AXI_RDATA; fin_resp_s = M_AXI_RRESP;
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE; awvalid_d = 1'b0; wvalid_d = 1'b0;
        bready_d = 1'b0; arvalid_d = 1'b0; rready_d = 1'b0;
      end
    endcase
    done0_d = fin_s && !gnt1_d;
    done1_d = fin_s && gnt1_d;
    if (done0_d) begin
      rdata0_d = fin_rdata_s; resp0_d = fin_resp_s;
    end else begin
      rdata0_d = '0; resp0_d = 2'b00;
    end
    if (done1_d) begin
      rdata1_d = fin_rdata_s; resp1_d = fin_resp_s;
    end else begin
      rdata1_d = '0; resp1_d = 2'b00;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE; ptr_q <= 1'b1; gnt1_q <= 1'b0; wr_q <= 1'b0;
      addr_q <= '0; wdata_q <= '0;
      awvalid_q <= 1'b0; wvalid_q <= 1'b0; bready_q <= 1'b0;
      arvalid_q <= 1'b0; rready_q <= 1'b0;
      done0_q <= 1'b0; done1_q <= 1'b0;
      rdata0_q <= '0; rdata1_q <= '0; resp0_q <= 2'b00; resp1_q <= 2'b00;
    end else begin
      state_q <= state_d; ptr_q <= ptr_d; gnt1_q <= gnt1_d; wr_q <= wr_d;
      addr_q <= addr_d; wdata_q <= wdata_d;
      awvalid_q <= awvalid_d; wvalid_q <= wvalid_d; bready_q <= bready_d;
      arvalid_q <= arvalid_d; rready_q <= rready_d;
      done0_q <= done0_d; done1_q <= done1_d;
      rdata0_q <= rdata0_d; rdata1_q <= rdata1_d; resp0_q <= resp0_d; resp1_q <= resp1_d;
    end
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign req0_done  = done0_q;
  assign req0_rdata = rdata0_q;
  assign req0_resp  = resp0_q;
  assign req1_done  = done1_q;
  assign req1_rdata = rdata1_q;
  assign req1_resp  = resp1_q;

endmodule

// File: tb/tb_full_axi_lite_arbiter.sv
// Self-checking bench: AXI4-Lite register slave with programmable delays plus a
// transaction-level reference (register array, last-grant bit, latency formulas).
module tb_full_axi_lite_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic ACLK = 1'b0;
  logic ARESET;
  logic req0_valid, req0_write, req0_done, req1_valid, req1_write, req1_done;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req0_rdata, req1_wdata, req1_rdata;
  logic [1:0] req0_resp, req1_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
  logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0] M_AXI_WSTRB;
  logic [1:0] M_AXI_BRESP, M_AXI_RRESP;

  int n_checks = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  full_axi_lite_arbiter #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model (4 x 32-bit registers, strobe-aware) ----------------
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, ar_cnt, r_wait;
  logic aw_got, w_got, r_pend, bvalid_q, rvalid_q;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q, rdata_q;
  logic [3:0] w_strb_q;
  logic [31:0] smem [4];
  logic aw_hs, w_hs, ar_hs;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;
  logic [3:0] wr_s;

  assign M_AXI_AWREADY = (aw_cnt >= aw_dly) && !aw_got;
  assign M_AXI_WREADY  = (w_cnt >= w_dly) && !w_got;
  assign M_AXI_ARREADY = (ar_cnt >= ar_dly) && !r_pend && !rvalid_q;
  assign M_AXI_BVALID  = bvalid_q;
  assign M_AXI_BRESP   = 2'b00;
  assign M_AXI_RVALID  = rvalid_q;
  assign M_AXI_RDATA   = rdata_q;
  assign M_AXI_RRESP   = 2'b00;
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign wr_a  = aw_hs ? M_AXI_AWADDR : aw_addr_q;
  assign wr_d  = w_hs ? M_AXI_WDATA : w_data_q;
  assign wr_s  = w_hs ? M_AXI_WSTRB : w_strb_q;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0; bvalid_q <= 1'b0; rvalid_q <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0; rdata_q <= '0;
      for (int i = 0; i < 4; i++) smem[i] <= 32'h0;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= M_AXI_AWADDR; end
      if (w_hs) begin w_got <= 1'b1; w_data_q <= M_AXI_WDATA; w_strb_q <= M_AXI_WSTRB; end
      if (bvalid_q && M_AXI_BREADY) begin
        bvalid_q <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (!bvalid_q && (aw_got || aw_hs) && (w_got || w_hs)) begin
        bvalid_q <= 1'b1;
        for (int b = 0; b < 4; b++)
          if (wr_s[b]) smem[wr_a[3:2]][b*8 +: 8] <= wr_d[b*8 +: 8];
      end
      if (ar_hs) begin
        rdata_q <= smem[M_AXI_ARADDR[3:2]];
        if (r_dly == 0) rvalid_q <= 1'b1;
        else begin r_pend <= 1'b1; r_wait <= r_dly - 1; end
      end else if (rvalid_q && M_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end else if (r_pend) begin
        if (r_wait == 0) begin rvalid_q <= 1'b1; r_pend <= 1'b0; end
        else r_wait <= r_wait - 1;
      end
    end
  end

  // ---------------- reference state ----------------
  logic [31:0] model_mem [4];
  logic model_last;

  task automatic drive(input logic idx, input logic wr, input logic [3:0] a, input logic [31:0] d);
    if (idx) begin req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d; end
    else begin req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = d; end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) model_mem[i] = 32'h0;
    model_last = 1'b1;
  endtask

  // One request on one port; returns cycles from grant sample (cycle 0) to done pulse.
  task automatic run_single(input logic idx, input logic wr, input logic [3:0] a, input logic [31:0] d,
                            output int lat, output logic [31:0] rd, output logic [1:0] rs, output int oth);
    drive(idx, wr, a, d);
    lat = -1; rd = '0; rs = '0; oth = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge ACLK);
      if (idx ? req0_done : req1_done) oth++;
      if (idx ? req1_done : req0_done) begin
        lat = n; rd = idx ? req1_rdata : req0_rdata; rs = idx ? req1_resp : req0_resp;
        break;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (lat > 0) begin
      if (wr) model_mem[a[3:2]] = d;
      model_last = idx;
    end
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    drive(1'b0, 1'b1, 4'h4, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 4'h8, 32'h0);
    repeat (3) @(negedge ACLK);
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      n_fail++; $display("FAIL reset_axi_ctrl: got %b want 00000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
    end
    n_checks++;
    if ({req0_done, req1_done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_done: got %b want 00", {req0_done, req1_done});
    end
    n_checks++;
    if ({req0_rdata, req1_rdata, req0_resp, req1_resp} !== 68'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%b/%b want 0", req0_rdata, req1_rdata, req0_resp, req1_resp);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) model_mem[i] = 32'h0;
    model_last = 1'b1;
  endtask

  task automatic test_write_read();
    int lat, oth; logic [31:0] rd; logic [1:0] rs;
    run_single(1'b0, 1'b1, 4'h0, 32'h0000_0001, lat, rd, rs, oth);
    n_checks++;
    if (lat !== 3 || rs !== 2'b00 || rd !== 32'h0 || oth !== 0) begin
      n_fail++; $display("FAIL wr_basic: lat=%0d resp=%b rdata=%h other=%0d want 3/00/0/0", lat, rs, rd, oth);
    end
    run_single(1'b0, 1'b0, 4'h0, 32'h0, lat, rd, rs, oth);
    n_checks++;
    if (lat !== 3 || rs !== 2'b00 || rd !== 32'h0000_0001 || oth !== 0) begin
      n_fail++; $display("FAIL rd_basic: lat=%0d resp=%b rdata=%h other=%0d want 3/00/00000001/0", lat, rs, rd, oth);
    end
  endtask

  task automatic test_tie();
    int d0, d1, lat, oth; logic [31:0] rd, va, vb; logic [1:0] rs;
    va = $urandom; vb = $urandom;
    do_reset();
    drive(1'b0, 1'b1, 4'h4, va);
    drive(1'b1, 1'b1, 4'h8, vb);
    d0 = -1; d1 = -1;
    for (int n = 1; n <= 20 && (d0 < 0 || d1 < 0); n++) begin
      @(negedge ACLK);
      if (req0_done) begin d0 = n; req0_valid = 1'b0; end
      if (req1_done) begin d1 = n; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge ACLK);
    model_mem[1] = va; model_mem[2] = vb; model_last = 1'b1;
    n_checks++;
    if (d0 !== 3 || d1 !== 7) begin
      n_fail++; $display("FAIL tie_order: done0@%0d done1@%0d want 3 and 7", d0, d1);
    end
    run_single(1'b1, 1'b0, 4'h4, 32'h0, lat, rd, rs, oth);
    n_checks++;
    if (rd !== model_mem[1] || rs !== 2'b00) begin
      n_fail++; $display("FAIL tie_rb4: rdata=%h resp=%b want %h/00", rd, rs, model_mem[1]);
    end
    run_single(1'b0, 1'b0, 4'h8, 32'h0, lat, rd, rs, oth);
    n_checks++;
    if (rd !== model_mem[2] || rs !== 2'b00) begin
      n_fail++; $display("FAIL tie_rb8: rdata=%h resp=%b want %h/00", rd, rs, model_mem[2]);
    end
  endtask

  task automatic test_aw_delay();
    int aw_hi, w_hi, first_b, done_n, dones, lat, oth; logic [31:0] v, rd; logic [1:0] rs;
    logic fields_ok;
    v = $urandom; aw_dly = 3; w_dly = 0;
    aw_hi = 0; w_hi = 0; first_b = -1; done_n = -1; dones = 0; fields_ok = 1'b0;
    drive(1'b0, 1'b1, 4'hC, v);
    for (int n = 1; n <= 12; n++) begin
      @(negedge ACLK);
      if (n == 1) fields_ok = (M_AXI_AWADDR === 4'hC) && (M_AXI_WDATA === v) &&
                              (M_AXI_WSTRB === 4'hF) && (M_AXI_AWPROT === 3'b000);
      if (M_AXI_AWVALID) aw_hi++;
      if (M_AXI_WVALID) w_hi++;
      if (M_AXI_BREADY && first_b < 0) first_b = n;
      if (req0_done || req1_done) begin dones++; done_n = n; req0_valid = 1'b0; end
    end
    aw_dly = 0;
    model_mem[3] = v; model_last = 1'b0;
    n_checks++;
    if (!fields_ok) begin
      n_fail++; $display("FAIL aw_fields: addr=%h strb=%h prot=%b not C/F/000", M_AXI_AWADDR, M_AXI_WSTRB, M_AXI_AWPROT);
    end
    n_checks++;
    if (aw_hi !== 4 || w_hi !== 1) begin
      n_fail++; $display("FAIL aw_valid_len: awvalid %0d wvalid %0d cycles, want 4 and 1", aw_hi, w_hi);
    end
    n_checks++;
    if (first_b !== 5 || done_n !== 6 || dones !== 1) begin
      n_fail++; $display("FAIL aw_resp: bready@%0d done@%0d count %0d, want 5/6/1", first_b, done_n, dones);
    end
    run_single(1'b1, 1'b0, 4'hC, 32'h0, lat, rd, rs, oth);
    n_checks++;
    if (rd !== model_mem[3]) begin
      n_fail++; $display("FAIL aw_readback: got %h want %h", rd, model_mem[3]);
    end
  endtask

  task automatic test_reset_mid_read();
    int lat, oth, dones; logic [31:0] v, rd; logic [1:0] rs; logic ar_ok, rr_ok;
    do_reset();
    v = $urandom;
    run_single(1'b0, 1'b1, 4'h4, v, lat, rd, rs, oth);
    r_dly = 3;
    drive(1'b0, 1'b0, 4'h4, 32'h0);
    @(negedge ACLK);
    ar_ok = M_AXI_ARVALID && (M_AXI_ARADDR === 4'h4) && (M_AXI_ARPROT === 3'b000);
    @(negedge ACLK);
    rr_ok = M_AXI_RREADY;
    ARESET = 1'b1; req0_valid = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if (!ar_ok || rr_ok !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: arvalid/addr ok=%b rready=%b want 1/1", ar_ok, rr_ok);
    end
    n_checks++;
    if (M_AXI_ARVALID !== 1'b0 || M_AXI_RREADY !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_ctrl: arvalid=%b rready=%b want 0/0", M_AXI_ARVALID, M_AXI_RREADY);
    end
    ARESET = 1'b0; r_dly = 0;
    for (int i = 0; i < 4; i++) model_mem[i] = 32'h0;
    model_last = 1'b1;
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      if (req0_done || req1_done) dones++;
      @(negedge ACLK);
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL mid_no_done: %0d done pulses want 0", dones);
    end
    run_single(1'b0, 1'b0, 4'h4, 32'h0, lat, rd, rs, oth);
    n_checks++;
    if (lat !== 3 || rd !== model_mem[1] || rs !== 2'b00) begin
      n_fail++; $display("FAIL mid_reissue: lat=%0d rdata=%h resp=%b want 3/%h/00", lat, rd, rs, model_mem[1]);
    end
    run_single(1'b0, 1'b1, 4'h4, v, lat, rd, rs, oth);
    run_single(1'b0, 1'b0, 4'h4, 32'h0, lat, rd, rs, oth);
    n_checks++;
    if (rd !== v) begin
      n_fail++; $display("FAIL mid_after: rdata=%h want %h", rd, v);
    end
  endtask

  task automatic test_align();
    int lat, d0, d1; logic saw_ar; logic [3:0] ar_a; logic [31:0] rd; logic [1:0] rs;
    do_reset();
    model_mem[0] = $urandom;
    run_single(1'b1, 1'b1, 4'h0, model_mem[0], lat, rd, rs, d0);
    model_last = 1'b1;
    saw_ar = 1'b0; ar_a = 4'h0; lat = -1; rd = '0; rs = '0;
    drive(1'b0, 1'b0, 4'h2, 32'h0);
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(negedge ACLK);
      if (M_AXI_ARVALID && !saw_ar) begin saw_ar = 1'b1; ar_a = M_AXI_ARADDR; end
      if (req0_done) begin lat = n; rd = req0_rdata; rs = req0_resp; req0_valid = 1'b0; end
    end
    req0_valid = 1'b0;
    @(negedge ACLK);
    model_last = 1'b0;
`ifdef FULL_AXI_ARB_ALIGN_CHECK_EN
    n_checks++;
    if (saw_ar !== 1'b0 || lat !== 1 || rs !== 2'b10 || rd !== 32'h0) begin
      n_fail++; $display("FAIL align_reject: arvalid_seen=%b lat=%0d resp=%b rdata=%h want 0/1/10/0", saw_ar, lat, rs, rd);
    end
`else
    n_checks++;
    if (saw_ar !== 1'b1 || ar_a !== 4'h2 || lat !== 3 || rs !== 2'b00 || rd !== model_mem[0]) begin
      n_fail++; $display("FAIL align_fwd: ar_seen=%b araddr=%h lat=%0d resp=%b rdata=%h want 1/2/3/00/%h",
        saw_ar, ar_a, lat, rs, rd, model_mem[0]);
    end
`endif
    drive(1'b0, 1'b0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0);
    d0 = -1; d1 = -1;
    for (int n = 1; n <= 20 && (d0 < 0 || d1 < 0); n++) begin
      @(negedge ACLK);
      if (req0_done) begin d0 = n; req0_valid = 1'b0; end
      if (req1_done) begin d1 = n; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge ACLK);
    model_last = 1'b0;
    n_checks++;
    if (d1 !== 3 || d0 !== 7) begin
      n_fail++; $display("FAIL align_ptr: done1@%0d done0@%0d want 3 and 7", d1, d0);
    end
  endtask

  task automatic rand_delays();
    aw_dly = $urandom_range(3, 0); w_dly = $urandom_range(3, 0);
    ar_dly = $urandom_range(3, 0); r_dly = $urandom_range(2, 0);
  endtask

  task automatic test_fairness();
    logic cw [2]; logic [3:0] ca [2]; logic [31:0] cd [2];
    int cnt [2]; int last, total, gap, seq_bad, lat_bad, data_bad, both_bad;
    logic e; logic gi; logic [31:0] exp_rd;
    do_reset();
    rand_delays();
    for (int i = 0; i < 2; i++) begin
      cw[i] = 1'($urandom_range(1, 0)); ca[i] = 4'($urandom_range(3, 0) * 4); cd[i] = $urandom;
      drive(1'(i), cw[i], ca[i], cd[i]);
      cnt[i] = 0;
    end
    last = 0; total = 0; seq_bad = 0; lat_bad = 0; data_bad = 0; both_bad = 0;
    for (int n = 1; n <= 600 && total < 12; n++) begin
      @(negedge ACLK);
      if (req0_done && req1_done) both_bad++;
      if (req0_done || req1_done) begin
        e = !model_last; gi = req1_done;
        if (gi !== e) seq_bad++;
        gap = (total == 0 ? 3 : 4) + (cw[e] ? (aw_dly > w_dly ? aw_dly : w_dly) : ar_dly + r_dly);
        if (n - last !== gap) lat_bad++;
        exp_rd = cw[e] ? 32'h0 : model_mem[ca[e][3:2]];
        if ((gi ? req1_rdata : req0_rdata) !== exp_rd || (gi ? req1_resp : req0_resp) !== 2'b00 ||
            (gi ? req0_rdata : req1_rdata) !== 32'h0) data_bad++;
        if (cw[e]) model_mem[ca[e][3:2]] = cd[e];
        model_last = gi; cnt[gi]++; total++; last = n;
        rand_delays();
        if (total < 12) begin
          cw[gi] = 1'($urandom_range(1, 0)); ca[gi] = 4'($urandom_range(3, 0) * 4); cd[gi] = $urandom;
          drive(gi, cw[gi], ca[gi], cd[gi]);
        end else begin
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge ACLK);
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
    n_checks++;
    if (total !== 12 || cnt[0] !== 6 || cnt[1] !== 6) begin
      n_fail++; $display("FAIL rr_count: total=%0d req0=%0d req1=%0d want 12/6/6", total, cnt[0], cnt[1]);
    end
    n_checks++;
    if (seq_bad !== 0 || both_bad !== 0) begin
      n_fail++; $display("FAIL rr_alternate: %0d out-of-order grants, %0d double pulses, want 0/0", seq_bad, both_bad);
    end
    n_checks++;
    if (lat_bad !== 0) begin
      n_fail++; $display("FAIL rr_latency: %0d transactions with wrong done spacing, want 0", lat_bad);
    end
    n_checks++;
    if (data_bad !== 0) begin
      n_fail++; $display("FAIL rr_data: %0d transactions with wrong rdata/resp, want 0", data_bad);
    end
  endtask

  initial begin
    ARESET = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    model_last = 1'b1;
    for (int i = 0; i < 4; i++) model_mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_tie();
    test_aw_delay();
    test_reset_mid_read();
    test_align();
    test_fairness();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
